// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared bus-master state encoding and timeout defaults
package soc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAPT,
        ST_WR,
        ST_DONE,
        ST_ERR
    } bus_state_t;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int TIMER_W         = 4;

endpackage

// File: rtl/boot_wr_timer.sv
// rtl/boot_wr_timer.sv - write-ack timeout counter with clear and expire
module boot_wr_timer
    import soc_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic romclk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge romclk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the cycle whose tick would bring the count up to LIMIT.
    assign expire = tick && (count == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - copies the boot ROM image into RAM while holding the CPU
module boot_loader
    import soc_pkg::*;
#(
    parameter int                ROM_AW    = 5,
    parameter int                ROM_DEPTH = 32,
    parameter int                RAM_AW    = 12,
    parameter logic [RAM_AW-1:0] DEST_BASE = '0,
    parameter int                TIMEOUT   = TIMEOUT_DEFAULT,
    parameter int                AUTOSTART = 1
) (
    input  logic              romclk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_cs,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_dout,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_din,
    input  logic              ram_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    output logic [15:0]       checksum
);

    localparam logic [ROM_AW-1:0] LAST_INDEX = ROM_AW'(ROM_DEPTH - 1);
    localparam logic              AUTO_GO    = (AUTOSTART != 0);

    bus_state_t        state;
    bus_state_t        next_state;
    logic [ROM_AW-1:0] index;
    logic [15:0]       data;
    logic [15:0]       sum;
    logic              auto_pend;
    logic              go;
    logic              last_word;
    logic              expire;

    assign go        = start || auto_pend;
    assign last_word = (index == LAST_INDEX);

    boot_wr_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .romclk (romclk),
        .rst    (rst),
        .clear  (state != ST_WR),
        .tick   ((state == ST_WR) && !ram_ack),
        .expire (expire)
    );

    always_ff @(posedge romclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (go) begin
                    next_state = ST_RD;
                end
            end
            ST_RD:   next_state = ST_CAPT;
            ST_CAPT: next_state = ST_WR;
            ST_WR: begin
                // An ack arriving on the expiring cycle still completes the word.
                if (ram_ack) begin
                    next_state = last_word ? ST_DONE : ST_RD;
                end else if (expire) begin
                    next_state = ST_ERR;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge romclk or posedge rst) begin
        if (rst) begin
            index     <= '0;
            data      <= '0;
            sum       <= '0;
            auto_pend <= AUTO_GO;
        end else begin
            auto_pend <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (go) begin
                        index <= '0;
                        sum   <= '0;
                    end
                end
                ST_CAPT: begin
                    data <= rom_dout;
                    sum  <= sum + rom_dout;
                end
                ST_WR: begin
                    if (ram_ack && !last_word) begin
                        index <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_cs   = (state == ST_RD) || (state == ST_CAPT);
    assign rom_we   = 1'b0;
    assign rom_addr = index;
    assign ram_cs   = (state == ST_WR);
    assign ram_we   = (state == ST_WR);
    assign ram_addr = DEST_BASE + RAM_AW'(index);
    assign ram_din  = data;
    assign busy     = (state == ST_RD) || (state == ST_CAPT) || (state == ST_WR);
    assign done     = (state == ST_DONE);
    assign err      = (state == ST_ERR);
    assign cpu_hold = (state != ST_DONE);
    assign checksum = sum;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - scoreboard bench for boot_loader
module tb_boot_loader;

    logic        romclk = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic        rom_cs, rom_we, ram_cs, ram_we, ram_ack, busy, done, err, cpu_hold;
    logic [4:0]  rom_addr;
    logic [15:0] rom_dout, ram_din, checksum;
    logic [11:0] ram_addr;
    logic        rom_cs_b, rom_we_b, ram_cs_b, ram_we_b, busy_b, done_b, err_b, cpu_hold_b;
    logic [4:0]  rom_addr_b;
    logic [15:0] rom_dout_b, ram_din_b, checksum_b;
    logic [11:0] ram_addr_b;

    int tests = 0;
    int fails = 0;
    int mode = 0;
    int nak_addr = 0;
    int wr_age = 0;
    bit chk2 = 1'b0;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t q1[$];
    wr_t q2[$];
    logic [11:0] prev_addr;
    logic [15:0] prev_din;

    always #5 romclk = ~romclk;

    boot_loader dut (
        .romclk(romclk), .rst(rst), .start(start),
        .rom_cs(rom_cs), .rom_we(rom_we), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_ack(ram_ack), .busy(busy), .done(done), .err(err),
        .cpu_hold(cpu_hold), .checksum(checksum)
    );

    boot_loader #(.DEST_BASE(12'hFF0)) dut_wrap (
        .romclk(romclk), .rst(rst), .start(start),
        .rom_cs(rom_cs_b), .rom_we(rom_we_b), .rom_addr(rom_addr_b), .rom_dout(rom_dout_b),
        .ram_cs(ram_cs_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b),
        .ram_ack(ram_ack), .busy(busy_b), .done(done_b), .err(err_b),
        .cpu_hold(cpu_hold_b), .checksum(checksum_b)
    );

    function automatic logic [15:0] rom_word(int i);
        case (i)
            0:       return 16'hF200;
            1:       return 16'h4000;
            31:      return 16'hC01E;
            default: return 16'((i * 1841) + 4369);
        endcase
    endfunction

    function automatic logic [15:0] sum_to(int last);
        logic [15:0] s = '0;
        for (int i = 0; i <= last; i++) s = s + rom_word(i);
        return s;
    endfunction

    // Synchronous boot ROM: address registered while selected.
    always_ff @(posedge romclk) if (rom_cs) rom_dout <= rom_word(int'(rom_addr));
    always_ff @(posedge romclk) if (rom_cs_b) rom_dout_b <= rom_word(int'(rom_addr_b));

    assign ram_ack = ram_cs && ((mode == 0) || (mode == 1 && wr_age == 3) ||
                                (mode == 2 && int'(ram_addr) != nak_addr));

    always_ff @(posedge romclk) wr_age <= (ram_cs && !ram_ack) ? wr_age + 1 : 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int first, int last);
        for (int i = first; i <= last; i++) begin
            q1.push_back('{addr: 12'(i), data: rom_word(i)});
            q2.push_back('{addr: 12'hFF0 + 12'(i), data: rom_word(i)});
        end
    endtask

    task automatic monitor();
        wr_t e;
        if (ram_cs && wr_age != 0) begin
            check("addr_stable", 32'(ram_addr), 32'(prev_addr));
            check("din_stable", 32'(ram_din), 32'(prev_din));
        end
        prev_addr = ram_addr;
        prev_din  = ram_din;
        if (ram_cs && ram_we && ram_ack) begin
            check("sb_pending", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(e.addr));
                check("wr_data", 32'(ram_din), 32'(e.data));
            end
        end
        if (chk2 && ram_cs_b && ram_we_b && ram_ack) begin
            check("sb2_pending", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                check("wrap_addr", 32'(ram_addr_b), 32'(e.addr));
                check("wrap_data", 32'(ram_din_b), 32'(e.data));
            end
        end
    endtask

    task automatic cyc();
        @(negedge romclk);
        monitor();
    endtask

    initial begin
        int n;
        int wr5;
        bit pulsed;
        bit any;

        repeat (3) cyc();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_hold", 32'(cpu_hold), 1);
        check("rst_strobes", {rom_cs, rom_we, ram_cs, ram_we}, 0);
        check("rst_cks", 32'(checksum), 0);

        // Autostart copy, ack always ready; wrapped-destination instance in lockstep.
        chk2 = 1'b1;
        push(0, 31);
        rst = 1'b0;
        for (int c = 1; c <= 97; c++) begin
            cyc();
            if (c == 1) check("auto_first_addr", {27'd0, rom_cs, rom_addr}, 32'h20);
            if (c == 96) check("done_early", 32'(done), 0);
            if (c == 97) begin
                check("done_97", 32'(done), 1);
                check("hold_97", 32'(cpu_hold), 0);
            end
        end
        check("cks_a", 32'(checksum), 32'(sum_to(31)));
        check("q1_drain_a", q1.size(), 0);
        check("q2_drain_a", q2.size(), 0);
        chk2 = 1'b0;
        q2.delete();

        // Restart from DONE with delayed ack and an ignored mid-copy start.
        mode = 1;
        push(0, 31);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 1;
        pulsed = 1'b0;
        while (!done && n < 400) begin
            if (!pulsed && rom_cs && rom_addr == 5'd10) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            cyc();
            start = 1'b0;
            n++;
        end
        check("mid_start_seen", 32'(pulsed), 1);
        check("slow_cycles", n, 193);
        check("cks_b", 32'(checksum), 32'(sum_to(31)));
        check("q1_drain_b", q1.size(), 0);

        // Word 5 never acknowledged.
        mode = 2;
        nak_addr = 5;
        push(0, 4);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        wr5 = 0;
        while (!err && n < 300) begin
            if (ram_cs && ram_addr == 12'd5) wr5++;
            cyc();
            n++;
        end
        check("to_wr_cycles", wr5, 15);
        check("to_err", 32'(err), 1);
        check("to_hold", 32'(cpu_hold), 1);
        check("to_busy", 32'(busy), 0);
        check("to_cks", 32'(checksum), 32'(sum_to(5)));
        check("q1_drain_c", q1.size(), 0);
        any = 1'b0;
        repeat (4) begin
            cyc();
            any = any | ram_cs | rom_cs;
        end
        check("err_quiet", 32'(any), 0);
        check("err_cks_hold", 32'(checksum), 32'(sum_to(5)));

        // Restart from ERR, then reset during the write of word 20.
        nak_addr = 20;
        push(0, 19);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (!(ram_cs && ram_addr == 12'd20) && n < 300) begin
            cyc();
            n++;
        end
        check("reach_w20", {19'd0, ram_cs, ram_addr}, 32'h1014);
        #1 rst = 1'b1;
        #1;
        check("abort_strobes", {rom_cs, ram_cs, ram_we, busy}, 0);
        check("abort_hold", 32'(cpu_hold), 1);
        check("abort_cks", 32'(checksum), 0);
        check("q1_drain_d", q1.size(), 0);
        cyc();
        cyc();
        mode = 0;
        push(0, 31);
        rst = 1'b0;
        cyc();
        check("recopy_first", {27'd0, rom_cs, rom_addr}, 32'h20);
        n = 1;
        while (!done && n < 200) begin
            cyc();
            n++;
        end
        check("recopy_cycles", n, 97);
        check("cks_d", 32'(checksum), 32'(sum_to(31)));
        check("q1_drain_d2", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
